// File: rtl/aud_ctrl_pkg.sv
// Shared types for the audio transport controller: FSM state encoding
// and the slot base-address helper.
// Imported by aud_transport_ctrl; the state values are visible on o_state.
package aud_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_I2C        = 3'd1,
      S_RECD       = 3'd2,
      S_RECD_PAUSE = 3'd3,
      S_PLAY       = 3'd4,
      S_PLAY_PAUSE = 3'd5,
      S_LOOP       = 3'd6
   } state_t;

   // Word address of the first word of a slot. Slots are equal
   // power-of-two regions, so the slot index simply sits above the offset
   // bits; this is a placement, never an addition that could carry.
   function automatic logic [31:0] slot_base(input logic [3:0] slot,
                                             input int unsigned off_w);
      return {28'd0, slot} << off_w;
   endfunction

endpackage

// File: rtl/aud_key_edge.sv
// Key rising-edge detector: registers the key level once and flags the
// cycle in which the level is high but was low on the previous clock.
// Ports: clk, rst (async, active high), key (level), key_edge (1-cycle pulse).
module aud_key_edge (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic key_edge
);

   logic key_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_d <= 1'b0;
      end else begin
         key_d <= key;
      end
   end

   // A held key produces exactly one pulse, on its first high cycle.
   assign key_edge = key & ~key_d;

endmodule

// File: rtl/aud_transport_ctrl.sv
// Audio transport controller: codec init sequencing, then a record/play/
// pause/stop FSM over NUM_SLOTS equal SRAM slots with per-slot end offsets.
// Ports: i_clk/i_rst, key levels (i_key_*), slot/loop select, completion
// flags from I2C/recorder/DSP, offsets in; recorder/DSP control levels,
// SRAM address/we_n, slot-valid map and o_state out.
// Optional feature: define AUD_LOOP_EN to enable looped playback (S_LOOP).
module aud_transport_ctrl
   import aud_ctrl_pkg::*;
#(
   parameter int ADDR_W    = 20,
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   parameter int I2C_HOLD  = 2048
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_key_rec,
   input  logic                     i_key_play,
   input  logic                     i_key_stop,
   input  logic [SLOT_W-1:0]        i_slot,
   input  logic                     i_loop,
   input  logic                     i_i2c_fin,
   input  logic                     i_rec_fin,
   input  logic                     i_play_fin,
   input  logic [ADDR_W-SLOT_W-1:0] i_rec_off,
   input  logic [ADDR_W-SLOT_W-1:0] i_play_off,
   output logic                     o_i2c_start,
   output logic                     o_rec_start,
   output logic                     o_rec_pause,
   output logic                     o_rec_stop,
   output logic                     o_dsp_start,
   output logic                     o_dsp_pause,
   output logic                     o_dsp_stop,
   output logic                     o_play_en,
   output logic [ADDR_W-SLOT_W-1:0] o_stop_off,
   output logic [ADDR_W-1:0]        o_sram_addr,
   output logic                     o_sram_we_n,
   output logic [NUM_SLOTS-1:0]     o_slot_valid,
   output logic [2:0]               o_state
);

   localparam int OFF_W = ADDR_W - SLOT_W;
   localparam int CNT_W = $clog2(I2C_HOLD) + 1;
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(I2C_HOLD - 1);

   state_t              state;
   logic [CNT_W-1:0]    hold_cnt;
   logic [SLOT_W-1:0]   active_slot;
   logic [SLOT_W-1:0]   slot_sel;
   logic [OFF_W-1:0]    end_off [NUM_SLOTS];
   logic [OFF_W-1:0]    off_sel;

   logic rec_edge, play_edge, stop_edge;
   logic stop_ev, rec_ev, play_ev;

   aud_key_edge u_key_rec (
      .clk      (i_clk),
      .rst      (i_rst),
      .key      (i_key_rec),
      .key_edge (rec_edge)
   );

   aud_key_edge u_key_play (
      .clk      (i_clk),
      .rst      (i_rst),
      .key      (i_key_play),
      .key_edge (play_edge)
   );

   aud_key_edge u_key_stop (
      .clk      (i_clk),
      .rst      (i_rst),
      .key      (i_key_stop),
      .key_edge (stop_edge)
   );

   // Coincident edges collapse to one event, stop > rec > play. A lower
   // priority edge is swallowed even if the winner has no effect in the
   // current state, so a sloppy multi-key press never does two things.
   assign stop_ev = stop_edge;
   assign rec_ev  = rec_edge & ~stop_edge;
   assign play_ev = play_edge & ~stop_edge & ~rec_edge;

   // A single-slot build has a 1-bit index that must always read slot 0.
   assign slot_sel = (NUM_SLOTS == 1) ? '0 : i_slot;

`ifndef AUD_LOOP_EN
   logic unused_loop;
   assign unused_loop = i_loop;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= S_I2C;
         hold_cnt     <= '0;
         active_slot  <= '0;
         o_slot_valid <= '0;
         o_i2c_start  <= 1'b0;
         o_rec_start  <= 1'b0;
         o_rec_pause  <= 1'b0;
         o_rec_stop   <= 1'b0;
         o_dsp_start  <= 1'b0;
         o_dsp_pause  <= 1'b0;
         o_dsp_stop   <= 1'b0;
         o_play_en    <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            end_off[i] <= '0;
         end
      end else begin
         case (state)
            S_I2C: begin
               // Keys are deliberately not looked at until the codec is up.
               if (i_i2c_fin) begin
                  state       <= S_IDLE;
                  o_i2c_start <= 1'b0;
               end else if (hold_cnt < HOLD_MAX) begin
                  hold_cnt    <= hold_cnt + 1'b1;
                  o_i2c_start <= 1'b1;
               end else begin
                  o_i2c_start <= 1'b0;
               end
            end

            S_IDLE: begin
               if (rec_ev) begin
                  active_slot <= slot_sel;
                  state       <= S_RECD;
                  o_rec_start <= 1'b1;
                  o_rec_stop  <= 1'b0;
                  o_dsp_stop  <= 1'b0;
               end else if (play_ev && o_slot_valid[slot_sel]) begin
                  active_slot <= slot_sel;
                  state       <= S_PLAY;
                  o_dsp_start <= 1'b1;
                  o_play_en   <= 1'b1;
                  o_dsp_stop  <= 1'b0;
               end
            end

            S_RECD: begin
               if (stop_ev || i_rec_fin) begin
                  state                 <= S_IDLE;
                  o_rec_stop            <= 1'b1;
                  o_rec_start           <= 1'b0;
                  end_off[active_slot]  <= i_rec_off;
                  o_slot_valid[active_slot] <= 1'b1;
               end else if (rec_ev) begin
                  state       <= S_RECD_PAUSE;
                  o_rec_pause <= 1'b1;
                  o_rec_start <= 1'b0;
               end
            end

            S_RECD_PAUSE: begin
               // The recorder's position is frozen while paused, so its
               // offset is still the correct end of the recording.
               if (stop_ev) begin
                  state                 <= S_IDLE;
                  o_rec_stop            <= 1'b1;
                  o_rec_pause           <= 1'b0;
                  end_off[active_slot]  <= i_rec_off;
                  o_slot_valid[active_slot] <= 1'b1;
               end else if (rec_ev) begin
                  state       <= S_RECD;
                  o_rec_start <= 1'b1;
                  o_rec_pause <= 1'b0;
               end
            end

            S_PLAY: begin
               if (stop_ev) begin
                  state       <= S_IDLE;
                  o_dsp_stop  <= 1'b1;
                  o_dsp_start <= 1'b0;
                  o_play_en   <= 1'b0;
               end else if (i_play_fin) begin
`ifdef AUD_LOOP_EN
                  if (i_loop) begin
                     // Restart the DSP without dropping the player enable.
                     state       <= S_LOOP;
                     o_dsp_stop  <= 1'b1;
                     o_dsp_start <= 1'b0;
                  end else begin
                     state       <= S_IDLE;
                     o_dsp_stop  <= 1'b1;
                     o_dsp_start <= 1'b0;
                     o_play_en   <= 1'b0;
                  end
`else
                  state       <= S_IDLE;
                  o_dsp_stop  <= 1'b1;
                  o_dsp_start <= 1'b0;
                  o_play_en   <= 1'b0;
`endif
               end else if (play_ev) begin
                  state       <= S_PLAY_PAUSE;
                  o_dsp_pause <= 1'b1;
                  o_dsp_start <= 1'b0;
                  o_play_en   <= 1'b0;
               end
            end

            S_PLAY_PAUSE: begin
               if (stop_ev) begin
                  state       <= S_IDLE;
                  o_dsp_stop  <= 1'b1;
                  o_dsp_pause <= 1'b0;
               end else if (play_ev) begin
                  state       <= S_PLAY;
                  o_dsp_start <= 1'b1;
                  o_play_en   <= 1'b1;
                  o_dsp_pause <= 1'b0;
               end
            end

`ifdef AUD_LOOP_EN
            S_LOOP: begin
               if (stop_ev) begin
                  state       <= S_IDLE;
                  o_dsp_stop  <= 1'b1;
                  o_dsp_start <= 1'b0;
                  o_play_en   <= 1'b0;
               end else begin
                  state       <= S_PLAY;
                  o_dsp_start <= 1'b1;
                  o_dsp_stop  <= 1'b0;
               end
            end
`endif

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // The recorder owns the bus while a recording is open (even paused);
   // the DSP owns it otherwise.
   assign off_sel = (state == S_RECD || state == S_RECD_PAUSE) ? i_rec_off
                                                                : i_play_off;

   assign o_sram_addr = ADDR_W'(slot_base(4'(active_slot), OFF_W))
                      | ADDR_W'(off_sel);
   assign o_stop_off  = end_off[active_slot];
   assign o_sram_we_n = (state != S_RECD);
   assign o_state     = state;

endmodule

// File: tb/tb_aud_transport_ctrl.sv
module tb_aud_transport_ctrl;

   localparam int ADDR_W    = 20;
   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;
   localparam int I2C_HOLD  = 8;
   localparam int OFF_W     = ADDR_W - SLOT_W;
`ifdef AUD_LOOP_EN
   localparam bit LOOP_ON = 1'b1;
`else
   localparam bit LOOP_ON = 1'b0;
`endif

   logic                 i_clk = 1'b0;
   logic                 i_rst = 1'b1;
   logic                 i_key_rec = 1'b0;
   logic                 i_key_play = 1'b0;
   logic                 i_key_stop = 1'b0;
   logic [SLOT_W-1:0]    i_slot = '0;
   logic                 i_loop = 1'b0;
   logic                 i_i2c_fin = 1'b0;
   logic                 i_rec_fin = 1'b0;
   logic                 i_play_fin = 1'b0;
   logic [OFF_W-1:0]     i_rec_off = '0;
   logic [OFF_W-1:0]     i_play_off = '0;
   logic                 o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop;
   logic                 o_dsp_start, o_dsp_pause, o_dsp_stop, o_play_en;
   logic [OFF_W-1:0]     o_stop_off;
   logic [ADDR_W-1:0]    o_sram_addr;
   logic                 o_sram_we_n;
   logic [NUM_SLOTS-1:0] o_slot_valid;
   logic [2:0]           o_state;

   aud_transport_ctrl #(
      .ADDR_W    (ADDR_W),
      .NUM_SLOTS (NUM_SLOTS),
      .SLOT_W    (SLOT_W),
      .I2C_HOLD  (I2C_HOLD)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_key_rec    (i_key_rec),
      .i_key_play   (i_key_play),
      .i_key_stop   (i_key_stop),
      .i_slot       (i_slot),
      .i_loop       (i_loop),
      .i_i2c_fin    (i_i2c_fin),
      .i_rec_fin    (i_rec_fin),
      .i_play_fin   (i_play_fin),
      .i_rec_off    (i_rec_off),
      .i_play_off   (i_play_off),
      .o_i2c_start  (o_i2c_start),
      .o_rec_start  (o_rec_start),
      .o_rec_pause  (o_rec_pause),
      .o_rec_stop   (o_rec_stop),
      .o_dsp_start  (o_dsp_start),
      .o_dsp_pause  (o_dsp_pause),
      .o_dsp_stop   (o_dsp_stop),
      .o_play_en    (o_play_en),
      .o_stop_off   (o_stop_off),
      .o_sram_addr  (o_sram_addr),
      .o_sram_we_n  (o_sram_we_n),
      .o_slot_valid (o_slot_valid),
      .o_state      (o_state)
   );

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: what the transport is doing (mode plus pause/loop
   // flags), the last level commanded on each control line, and what each
   // slot holds.
   localparam int M_INIT = 0;
   localparam int M_IDLE = 1;
   localparam int M_REC  = 2;
   localparam int M_PLAY = 3;

   int          m_mode;
   int          m_k;
   bit          m_paused;
   bit          m_loop;
   int          m_slot;
   bit          m_valid [NUM_SLOTS];
   logic [31:0] m_end   [NUM_SLOTS];
   bit          pk_rec, pk_play, pk_stop;
   bit          mr_start, mr_pause, mr_stop, md_start, md_pause, md_stop, m_play_en;

   task automatic model_reset();
      m_mode = M_INIT; m_k = 0; m_paused = 0; m_loop = 0; m_slot = 0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         m_valid[i] = 0;
         m_end[i]   = '0;
      end
      pk_rec = 0; pk_play = 0; pk_stop = 0;
      mr_start = 0; mr_pause = 0; mr_stop = 0;
      md_start = 0; md_pause = 0; md_stop = 0; m_play_en = 0;
   endtask

   task automatic finish_play();
      m_mode = M_IDLE; m_paused = 0; m_loop = 0;
      md_stop = 1; md_start = 0; md_pause = 0; m_play_en = 0;
   endtask

   task automatic model_step();
      bit se, rise_r, rise_p, re, pe;
      se     = i_key_stop && !pk_stop;
      rise_r = i_key_rec && !pk_rec;
      rise_p = i_key_play && !pk_play;
      re     = rise_r && !se;
      pe     = rise_p && !se && !rise_r;
      pk_stop = i_key_stop; pk_rec = i_key_rec; pk_play = i_key_play;
      case (m_mode)
         M_INIT: begin
            if (i_i2c_fin) m_mode = M_IDLE;
            else m_k++;
         end
         M_IDLE: begin
            if (re) begin
               m_slot = int'(i_slot); m_mode = M_REC; m_paused = 0;
               mr_start = 1; mr_stop = 0; md_stop = 0;
            end else if (pe && m_valid[i_slot]) begin
               m_slot = int'(i_slot); m_mode = M_PLAY; m_paused = 0;
               md_start = 1; m_play_en = 1; md_stop = 0;
            end
         end
         M_REC: begin
            if (se || (!m_paused && i_rec_fin)) begin
               m_mode = M_IDLE; m_paused = 0;
               mr_stop = 1; mr_start = 0; mr_pause = 0;
               m_end[m_slot] = 32'(i_rec_off); m_valid[m_slot] = 1;
            end else if (re) begin
               m_paused = !m_paused;
               mr_pause = m_paused; mr_start = !m_paused;
            end
         end
         default: begin
            if (se) begin
               finish_play();
            end else if (m_loop) begin
               m_loop = 0; md_start = 1; md_stop = 0;
            end else if (!m_paused && i_play_fin) begin
               if (LOOP_ON && i_loop) begin
                  m_loop = 1; md_stop = 1; md_start = 0;
               end else begin
                  finish_play();
               end
            end else if (pe) begin
               m_paused = !m_paused;
               md_pause = m_paused; md_start = !m_paused; m_play_en = !m_paused;
            end
         end
      endcase
   endtask

   function automatic int exp_state();
      case (m_mode)
         M_INIT:  return 1;
         M_IDLE:  return 0;
         M_REC:   return m_paused ? 3 : 2;
         default: return m_loop ? 6 : (m_paused ? 5 : 4);
      endcase
   endfunction

   task automatic check_all();
      logic [NUM_SLOTS-1:0] v;
      logic [31:0] e_addr;
      bit e_i2c;
      for (int i = 0; i < NUM_SLOTS; i++) v[i] = m_valid[i];
      e_i2c  = (m_mode == M_INIT) && (m_k >= 1) && (m_k <= I2C_HOLD - 1);
      e_addr = 32'(m_slot) * (32'd1 << OFF_W)
             + 32'((m_mode == M_REC) ? i_rec_off : i_play_off);
      chk("state", 32'(o_state), 32'(exp_state()));
      chk("ctl", 32'({o_i2c_start, o_rec_start, o_rec_pause, o_rec_stop,
                      o_dsp_start, o_dsp_pause, o_dsp_stop, o_play_en}),
                 32'({e_i2c, mr_start, mr_pause, mr_stop,
                      md_start, md_pause, md_stop, m_play_en}));
      chk("we_n", 32'(o_sram_we_n), 32'(!(m_mode == M_REC && !m_paused)));
      chk("valid", 32'(o_slot_valid), 32'(v));
      chk("stop_off", 32'(o_stop_off), m_end[m_slot]);
      chk("addr", 32'(o_sram_addr), e_addr);
   endtask

   task automatic cycle();
      @(posedge i_clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_key_rec = 0; i_key_play = 0; i_key_stop = 0;
      i_i2c_fin = 0; i_rec_fin = 0; i_play_fin = 0; i_loop = 0;
      repeat (2) @(posedge i_clk);
      #1;
      model_reset();
      check_all();
      i_rst = 1'b0;
   endtask

   initial begin
      int hi_cnt;
      int trans;
      logic [2:0] prev;

      do_reset();

      // Codec init hold: start level high for I2C_HOLD-1 cycles.
      hi_cnt = 0;
      for (int n = 0; n < 10; n++) begin
         cycle();
         if (o_i2c_start) hi_cnt++;
      end
      chk("i2c_hi_cycles", 32'(hi_cnt), 32'(I2C_HOLD - 1));
      i_i2c_fin = 1; cycle(); i_i2c_fin = 0;
      chk("idle_after_fin", 32'(o_state), 32'd0);

      // Record into slot 2, end offset 0x100.
      i_slot = 2'd2; i_key_rec = 1; cycle();
      chk("rec_state", 32'(o_state), 32'd2);
      i_key_rec = 0; i_rec_off = 18'h100; cycle();
      chk("rec_addr", 32'(o_sram_addr), 32'h80100);
      i_key_stop = 1; cycle();
      chk("slot2_valid", 32'(o_slot_valid), 32'h4);
      i_key_stop = 0; cycle();

      // Play on an empty slot is ignored.
      i_slot = 2'd1; i_key_play = 1; cycle();
      chk("empty_play_state", 32'(o_state), 32'd0);
      chk("empty_play_dsp", 32'({o_dsp_start, o_dsp_pause, o_dsp_stop, o_play_en}), 32'd0);
      i_key_play = 0; cycle();

      // Play slot 2.
      i_slot = 2'd2; i_play_off = 18'h100; i_key_play = 1; cycle();
      chk("play_state", 32'(o_state), 32'd4);
      chk("play_stop_off", 32'(o_stop_off), 32'h100);
      chk("play_addr", 32'(o_sram_addr), 32'h80100);
      i_key_play = 0; cycle();
      i_key_stop = 1; cycle(); i_key_stop = 0; cycle();

      // Record, pause, resume.
      i_slot = 2'd0;
      i_key_rec = 1; cycle(); chk("r1_state", 32'(o_state), 32'd2);
      i_key_rec = 0; cycle();
      i_key_rec = 1; cycle(); chk("r2_state", 32'(o_state), 32'd3);
      chk("r2_pause", 32'(o_rec_pause), 32'd1);
      i_key_rec = 0; cycle(); chk("r2_pause_hold", 32'(o_rec_pause), 32'd1);
      i_key_rec = 1; cycle(); chk("r3_state", 32'(o_state), 32'd2);
      chk("r3_pause", 32'(o_rec_pause), 32'd0);
      i_key_rec = 0; cycle();
      i_key_stop = 1; cycle(); i_key_stop = 0; cycle();

      // All three keys together in idle: stop wins, held keys do nothing.
      i_key_stop = 1; i_key_rec = 1; i_key_play = 1; cycle();
      chk("simul_stop_wins", 32'(o_state), 32'd0);
      repeat (20) cycle();
      i_key_stop = 0; i_key_rec = 0; i_key_play = 0; cycle();

      // A key held for 100 cycles acts once.
      trans = 0; prev = o_state;
      i_key_rec = 1;
      for (int n = 0; n < 100; n++) begin
         cycle();
         if (o_state != prev) trans++;
         prev = o_state;
      end
      chk("held_key_one_trans", 32'(trans), 32'd1);
      i_key_rec = 0; cycle();
      i_key_stop = 1; cycle(); i_key_stop = 0; cycle();

      // Play-finish with loop requested.
      i_slot = 2'd2; i_key_play = 1; cycle(); i_key_play = 0; cycle();
      i_loop = 1; i_play_fin = 1; cycle(); i_play_fin = 0;
      chk("loop_fin_state", 32'(o_state), LOOP_ON ? 32'd6 : 32'd0);
      chk("loop_fin_dsp_stop", 32'(o_dsp_stop), 32'd1);
      cycle();
      chk("loop_after_state", 32'(o_state), LOOP_ON ? 32'd4 : 32'd0);
      chk("loop_after_start", 32'(o_dsp_start), LOOP_ON ? 32'd1 : 32'd0);
      i_loop = 0;
      i_key_stop = 1; cycle(); i_key_stop = 0; cycle();

      // Randomised traffic against the model, with one reset mid-run.
      for (int n = 0; n < 4000; n++) begin
         if (n == 2000) do_reset();
         i_key_rec  = i_key_rec  ^ ($urandom_range(5) == 0);
         i_key_play = i_key_play ^ ($urandom_range(5) == 0);
         i_key_stop = i_key_stop ^ ($urandom_range(9) == 0);
         i_slot     = SLOT_W'($urandom_range(NUM_SLOTS - 1));
         i_loop     = ($urandom_range(1) == 1);
         i_i2c_fin  = ($urandom_range(19) == 0);
         i_rec_fin  = ($urandom_range(39) == 0);
         i_play_fin = ($urandom_range(29) == 0);
         i_rec_off  = OFF_W'($urandom);
         i_play_off = OFF_W'($urandom);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
